// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master round-robin Wishbone arbiter, cyc-framed grants
// Optional stalled-slave timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,

    output logic [1:0]    gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_gnt;     // 1 when master 1 held the most recent grant
    logic   enter;
    logic   timeout;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= state_next;
            if (enter) begin
                last_gnt <= (state_next == G1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next = last_gnt ? G0 : G1;
                end else if (m0_cyc_i) begin
                    state_next = G0;
                end else if (m1_cyc_i) begin
                    state_next = G1;
                end
            end
            G0: begin
                // A timed-out master loses the bus even if it still holds cyc
                if (timeout) begin
                    state_next = IDLE;
                end else if (!m0_cyc_i) begin
                    state_next = m1_cyc_i ? G1 : IDLE;
                end
            end
            G1: begin
                if (timeout) begin
                    state_next = IDLE;
                end else if (!m1_cyc_i) begin
                    state_next = m0_cyc_i ? G0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign enter = (state_next != state) && (state_next != IDLE);

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        case (state)
            G0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
            end
            G1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
            end
            default: ;
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i && (state == G0) && m0_stb_i && !timeout;
    assign m1_ack_o = s_ack_i && (state == G1) && m1_stb_i && !timeout;
    assign gnt_o    = {state == G1, state == G0};

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    logic [15:0] to_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || enter || s_ack_i || !s_stb_o) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    assign timeout  = s_stb_o && (to_cnt == TIMEOUT_CNT);
    assign m0_err_o = timeout && (state == G0);
    assign m1_err_o = timeout && (state == G1);
`else
    assign timeout  = 1'b0;
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - directed and randomized checks of wb_arbiter2 against an owner-based model
module tb_wb_arbiter2;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    cyc, stb, we;
    logic [AW-1:0] adr  [2];
    logic [DW-1:0] wdat [2];
    logic [DW-1:0] m0_dat, m1_dat;
    logic          m0_ack, m1_ack, m0_err, m1_err;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_o, s_dat_i;
    logic          s_ack;
    logic [1:0]    gnt;

    int checks = 0;
    int errors = 0;

    // reference model: who owns the bus (-1 = nobody), who owned it last, stall counter
    int owner;
    int last;
    int tcnt;

    logic [31:0] got [$];

    wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]),
        .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(m0_dat),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]),
        .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(m1_dat),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack),
        .gnt_o(gnt)
    );

    always #5 clk = ~clk;

    function automatic logic model_stb();
        return (owner >= 0) ? stb[owner] : 1'b0;
    endfunction

    function automatic logic model_err(int x);
`ifdef WB_ARB_TIMEOUT_EN
        return (owner == x) && stb[x] && (tcnt == TO);
`else
        return (x < 0);
`endif
    endfunction

    function automatic void model_edge();
        int nxt;
        if (rst) begin
            owner = -1;
            last  = 1;
            tcnt  = 0;
            return;
        end
        if (owner < 0) begin
            if (cyc[0] && cyc[1]) nxt = 1 - last;
            else if (cyc[0])      nxt = 0;
            else if (cyc[1])      nxt = 1;
            else                  nxt = -1;
        end else if (model_err(owner)) begin
            nxt = -1;
        end else if (cyc[owner]) begin
            nxt = owner;
        end else if (cyc[1-owner]) begin
            nxt = 1 - owner;
        end else begin
            nxt = -1;
        end
        if (nxt >= 0 && nxt != owner) begin
            last = nxt;
            tcnt = 0;
        end else if (model_stb() && !s_ack) begin
            tcnt = tcnt + 1;
        end else begin
            tcnt = 0;
        end
        owner = nxt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [1:0]    eg;
        logic          ec, es, ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        #2;
        eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        if (owner >= 0) begin
            ec = cyc[owner]; es = stb[owner]; ew = we[owner];
            ea = adr[owner]; ed = wdat[owner];
        end else begin
            ec = 1'b0; es = 1'b0; ew = 1'b0; ea = '0; ed = '0;
        end
        chk({tag, ".gnt"},   32'(gnt),     32'(eg));
        chk({tag, ".s_cyc"}, 32'(s_cyc),   32'(ec));
        chk({tag, ".s_stb"}, 32'(s_stb),   32'(es));
        chk({tag, ".s_we"},  32'(s_we),    32'(ew));
        chk({tag, ".s_adr"}, 32'(s_adr),   32'(ea));
        chk({tag, ".s_dat"}, 32'(s_dat_o), 32'(ed));
        chk({tag, ".m0_dat"}, 32'(m0_dat), 32'(s_dat_i));
        chk({tag, ".m1_dat"}, 32'(m1_dat), 32'(s_dat_i));
        chk({tag, ".m0_ack"}, 32'(m0_ack), 32'(s_ack && owner == 0 && stb[0] && !model_err(0)));
        chk({tag, ".m1_ack"}, 32'(m1_ack), 32'(s_ack && owner == 1 && stb[1] && !model_err(1)));
        chk({tag, ".m0_err"}, 32'(m0_err), 32'(model_err(0)));
        chk({tag, ".m1_err"}, 32'(m1_err), 32'(model_err(1)));
    endtask

    task automatic clear_inputs();
        cyc = '0; stb = '0; we = '0;
        adr[0] = '0; adr[1] = '0; wdat[0] = '0; wdat[1] = '0;
        s_ack = 1'b0; s_dat_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        owner = -1; last = 1; tcnt = 0;
        clear_inputs();
        do_reset();

        // reset state
        check_all("reset");
        chk("reset.gnt_const", 32'(gnt), 32'h0);

        // m0 read of 0x1234 returning 0xBEEF
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 16'h1234;
        check_all("rd.req");
        step();
        s_dat_i = 16'hBEEF; s_ack = 1'b1;
        check_all("rd.ack");
        chk("rd.gnt01", 32'(gnt), 32'h1);
        chk("rd.adr", 32'(s_adr), 32'h1234);
        chk("rd.dat", 32'(m0_dat), 32'hBEEF);
        chk("rd.m0_ack", 32'(m0_ack), 32'h1);
        chk("rd.m1_ack", 32'(m1_ack), 32'h0);
        step();
        clear_inputs();
        check_all("rd.drop");
        step();

        // three simultaneous requests from IDLE alternate m0, m1, m0
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc = 2'b11; stb = 2'b11;
            check_all("tie.req");
            step();
            chk("tie.gnt", 32'(gnt), (i % 2 == 1) ? 32'h2 : 32'h1);
            s_ack = 1'b1;
            check_all("tie.ack");
            step();
            cyc = 2'b00; stb = 2'b00; s_ack = 1'b0;
            check_all("tie.drop");
            step();
        end

        // m1 locks the bus for 4 write beats while m0 waits
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
        adr[1] = 16'h0010; wdat[1] = 16'h0010;
        check_all("blk.req");
        step();
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 16'h7777;
        got.delete();
        for (int k = 0; k < 4; k++) begin
            adr[1] = 16'(16'h0010 + k); wdat[1] = 16'(16'h0010 + k); s_ack = 1'b1;
            check_all("blk.beat");
            if (s_cyc && s_stb && s_we && s_ack) got.push_back({s_adr, s_dat_o});
            step();
        end
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0; s_ack = 1'b0;
        check_all("blk.drop");
        step();
        chk("blk.handover", 32'(gnt), 32'h1);
        check_all("blk.g0");
        chk("blk.count", 32'(got.size()), 32'd4);
        for (int k = 0; k < 4 && k < got.size(); k++)
            chk("blk.write", got[k], {16'(16'h0010 + k), 16'(16'h0010 + k)});
        clear_inputs();
        step();

        // reset in the middle of an m0 write
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 16'h0002; wdat[0] = 16'hA5A5;
        step();
        chk("rstmid.gnt", 32'(gnt), 32'h1);
        rst = 1'b1; s_ack = 1'b1;
        check_all("rstmid.assert");
        step();
        chk("rstmid.gnt_after", 32'(gnt), 32'h0);
        chk("rstmid.s_cyc", 32'(s_cyc), 32'h0);
        chk("rstmid.m0_ack", 32'(m0_ack), 32'h0);
        check_all("rstmid.after");
        rst = 1'b0;
        clear_inputs();
        step();

        // stray ack in IDLE
        s_ack = 1'b1; s_dat_i = 16'h5A5A;
        check_all("stray");
        chk("stray.m0_ack", 32'(m0_ack), 32'h0);
        chk("stray.m1_ack", 32'(m1_ack), 32'h0);
        step();
        clear_inputs();
        step();

`ifdef WB_ARB_TIMEOUT_EN
        // hung slave: m0 stalls, err after TO cycles, pending m1 then granted
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        step();
        for (int n = 0; n <= TO; n++) begin
            if (n == 3) cyc[1] = 1'b1;
            check_all("to.wait");
            chk("to.err", 32'(m0_err), (n == TO) ? 32'h1 : 32'h0);
            chk("to.ack", 32'(m0_ack), 32'h0);
            step();
        end
        chk("to.idle", 32'(gnt), 32'h0);
        check_all("to.idle");
        step();
        chk("to.m1", 32'(gnt), 32'h2);
        check_all("to.m1");
        clear_inputs();
        step();
`endif

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int m = 0; m < 2; m++) begin
                if (cyc[m]) begin
                    if ($urandom_range(0, 3) == 0) cyc[m] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    cyc[m] = 1'b1;
                end
                stb[m]  = cyc[m] && ($urandom_range(0, 3) != 0);
                we[m]   = 1'($urandom_range(0, 1));
                adr[m]  = 16'($urandom);
                wdat[m] = 16'($urandom);
            end
            s_ack   = 1'($urandom_range(0, 1));
            s_dat_i = 16'($urandom);
            check_all("rand");
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
